multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Finite-state controller that sequences a multicycle RV32I datapath sharing one unified instruction/data memory. It decodes the instruction register fields, steps each instruction through fetch/decode/execute/memory/writeback states, drives every datapath select and write strobe, and handshakes with a memory that may insert wait cycles. It also keeps a retired-instruction count and a sticky illegal-opcode fault flag.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero, Negative, V, Carry  in  1 each  ALU flags from the current-cycle ALU result
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write qualifier for mem_req
- AdrSrc  out  1  0=PC, 1=Result
- IRWrite, PCWrite, RegWrite  out  1 each  register load strobes
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1 reg
- ALUSrcB  out  2  00=RD2 reg, 01=ImmExt, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data reg, 10=ALUResult, 11=ImmExt
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt, 0110 xor, 0111 sll, 1000 srl, 1001 sra, 1010 sltu
- fault  out  1  sticky illegal-opcode flag
- instret  out  32  retired-instruction count

## Operation
- Moore FSM; outputs decode from state (plus mem_ready, funct3, flags where noted). ImmSrc decodes from op in every state. Unlisted strobes are 0 and unlisted selects are don't-care.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite=mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - else -> FAULT
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite. Then FETCH. Sub-word extraction by funct3 belongs to the datapath.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Hold until mem_ready, then FETCH.
- EXECR / EXECI:
  - ALUSrcA=10; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl comes from mc_aludec.
  - Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite. Then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=taken, where taken by funct3 is:
  - 000: Zero; 001: ~Zero
  - 100: Negative^V; 101: ~(Negative^V)
  - 110: ~Carry; 111: Carry
  - 010/011: 0
  - Then FETCH.
- JAL: PCWrite, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, add. Then ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, add. Then JALRPC.
- JALRPC: PCWrite, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, add. Then ALUWB. Clearing bit 0 of the target belongs to the datapath.
- LUI: ResultSrc=11, RegWrite. Then FETCH.
- AUIPC: ALUSrcA=01, ALUSrcB=01, add. Then ALUWB.
- FAULT: fault=1 and all strobes and mem_req are 0. Exit only by reset.
- mc_aludec:
  - ALUOp add -> 0000; ALUOp sub -> 0001.
  - ALU-op decode by funct3: 000 -> sub if funct7b5&op[5], else add; 001 -> sll; 010 -> slt; 011 -> sltu; 100 -> xor; 101 -> sra if funct7b5, else srl; 110 -> or; 111 -> and.
- instret increments by 1 on every transition into FETCH from a non-FETCH state, and wraps at 2^32.

## Timing
- Reset (asynchronous): state=FETCH, instret=0, fault=0.
- While reset is high: mem_req, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0.
- The first request is issued the cycle after reset falls.
- Cycles per instruction with mem_ready tied to 1:
  - lw 5, sw 4, R/I-ALU 4, branch 3
  - jal 4, jalr 5, lui 3, auipc 4
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- mem_req and MemWrite stay stable through wait cycles. The strobes IRWrite and PCWrite pulse only on the FETCH ready cycle.
- Reset mid-access: the request drops immediately and no strobe fires.

## Structure
- Package riscv_mc_pkg holds:
  - the state enum
  - opcode constants
  - ALUSrcA, ALUSrcB, ResultSrc, ImmSrc and ALUControl encodings
- One sub-module, mc_aludec, which is combinational ALUControl decode.
- The FSM and instret counter live in multicycle_controller.

## Test plan
- Reset held for 3 cycles, then released, with mem_ready=1 -> mem_req=0 during reset, FETCH request on the first cycle after release, IRWrite=PCWrite=1 in that cycle.
- lw (op 0000011) with mem_ready low for 2 cycles in MEMREAD -> 7 cycles total, RegWrite with ResultSrc=01 exactly once, instret +1.
- sw (op 0100011) -> MemWrite=1 with AdrSrc=1 for 1 cycle, RegWrite never asserted, 4 cycles.
- Branch funct3 sweep with flags forced: bne with Zero=1 -> PCWrite=0; blt with Negative=1, V=0 -> PCWrite=1; bgeu with Carry=0 -> PCWrite=0.
- R-type sub (funct7b5=1, funct3 000) -> ALUControl=0001; srai (op 0010011, funct3 101, funct7b5=1) -> 1001; addi with funct7b5=1 -> 0000.
- Opcode 0000000 -> FAULT after DECODE, fault=1, mem_req=0 forever, instret frozen; reset clears fault.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller:
// FSM states, opcodes, datapath select encodings and ALU control codes.
`timescale 1ns/1ps

package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRPC,
    S_LUI,
    S_AUIPC,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  // Immediate format is a pure function of the opcode, so it is valid in every state.
  function automatic logic [2:0] immSrcFor(input logic [6:0] opcode);
    logic [2:0] imm;
    case (opcode)
      OP_STORE:         imm = IMM_S;
      OP_BRANCH:        imm = IMM_B;
      OP_JAL:           imm = IMM_J;
      OP_LUI, OP_AUIPC: imm = IMM_U;
      default:          imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU control decode: forced add/sub from the FSM, or the
// operation selected by funct3/funct7b5 for register and immediate ALU ops.
`timescale 1ns/1ps

module mc_aludec
  import riscv_mc_pkg::*;
(
  input  aluop_t     aluOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [3:0] aluControl_o
);

  // Subtract only for R-type funct3=000 with funct7b5; addi never subtracts.
  always_comb begin
    aluControl_o = ALU_ADD;
    case (aluOp_i)
      ALUOP_ADD: aluControl_o = ALU_ADD;
      ALUOP_SUB: aluControl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          3'b000:  aluControl_o = (funct7b5_i & op5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  aluControl_o = ALU_SLL;
          3'b010:  aluControl_o = ALU_SLT;
          3'b011:  aluControl_o = ALU_SLTU;
          3'b100:  aluControl_o = ALU_XOR;
          3'b101:  aluControl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  aluControl_o = ALU_OR;
          default: aluControl_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: sequences fetch/decode/execute/memory/writeback
// over a shared memory with wait states, counts retired instructions and
// latches a sticky fault on an illegal opcode.
`timescale 1ns/1ps

module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  input  logic        Negative,
  input  logic        V,
  input  logic        Carry,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        fault,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        fault_q, fault_d;
  aluop_t      aluOp;
  logic        branchTaken;

  mc_aludec u_aludec (
    .aluOp_i      (aluOp),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .op5_i        (op[5]),
    .aluControl_o (ALUControl)
  );

  assign ImmSrc  = immSrcFor(op);
  assign fault   = fault_q;
  assign instret = instret_q;

  // Branch condition from the flags of the rs1-rs2 subtraction; funct3 010/011 never branch.
  always_comb begin
    branchTaken = 1'b0;
    case (funct3)
      3'b000:  branchTaken = Zero;
      3'b001:  branchTaken = ~Zero;
      3'b100:  branchTaken = Negative ^ V;
      3'b101:  branchTaken = ~(Negative ^ V);
      3'b110:  branchTaken = ~Carry;
      3'b111:  branchTaken = Carry;
      default: branchTaken = 1'b0;
    endcase
  end

  // Next-state and output decode; strobes and the request are squashed while reset is high.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    aluOp     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req   = 1'b1;
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        MemWrite  = 1'b1;
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        aluOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = branchTaken;
        state_d   = S_FETCH;
      end
      S_JAL, S_JALRPC: begin
        PCWrite   = 1'b1;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALRPC;
      end
      S_LUI: begin
        ResultSrc = RES_IMMEXT;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
    if (reset) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // An instruction retires on each return to FETCH; the fault flag sticks once FAULT is entered.
  always_comb begin
    instret_d = instret_q;
    if ((state_q != S_FETCH) && (state_d == S_FETCH)) instret_d = instret_q + 32'd1;
    fault_d = fault_q | (state_d == S_FAULT);
  end

  // State, retire counter and fault flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each issued instruction pushes its
// expected per-instruction footprint; a monitor accumulates the DUT's activity
// and compares it whenever the retire counter advances.
`timescale 1ns/1ps

module tb_multicycle_controller;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RT    = 7'b0110011;
  localparam logic [6:0] IT    = 7'b0010011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero, Negative, V, Carry;
  logic        mem_ready;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic        fault;
  logic [31:0] instret;

  typedef struct {
    int          cycles;
    int          irW;
    int          pcW;
    int          regW;
    int          memW;
    int          fetchReq;
    int          dataReq;
    logic        chkAlu;
    logic [1:0]  srcA;
    logic [1:0]  srcB;
    logic [3:0]  aluCtl;
    logic [2:0]  imm;
    logic [1:0]  res;
    logic [31:0] instretAfter;
  } exp_t;

  exp_t        expQ[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] modelCount = 0;
  logic        monEnable  = 1'b0;
  logic [31:0] lastInstret = 0;

  int          curCycles, curIr, curPc, curReg, curMemW, curFetchReq, curDataReq, sinceIr;
  logic [1:0]  seenA, seenB, lastRes;
  logic [3:0]  seenAlu;
  logic [2:0]  seenImm;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .Negative   (Negative),
    .V          (V),
    .Carry      (Carry),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .fault      (fault),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU operation table indexed by funct3, with the two funct7b5 variants.
  function automatic logic [3:0] aluModel(input logic [2:0] f3, input logic f7, input logic isReg);
    logic [3:0] tbl [8];
    tbl = '{4'b0000, 4'b0111, 4'b0101, 4'b1010, 4'b0110, 4'b1000, 4'b0011, 4'b0010};
    if (f3 == 3'd0 && f7 && isReg) return 4'b0001;
    if (f3 == 3'd5 && f7) return 4'b1001;
    return tbl[f3];
  endfunction

  function automatic logic [2:0] immModel(input logic [6:0] o);
    if (o == SW) return 3'b001;
    if (o == BR) return 3'b010;
    if (o == JAL) return 3'b011;
    if (o == LUI || o == AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  // flags packed as {Zero, Negative, V, Carry}
  function automatic int takenModel(input logic [2:0] f3, input logic [3:0] flg);
    logic z, n, v, c;
    {z, n, v, c} = flg;
    case (f3)
      3'd0: return int'(z);
      3'd1: return int'(!z);
      3'd4: return int'(n != v);
      3'd5: return int'(n == v);
      3'd6: return int'(!c);
      3'd7: return int'(c);
      default: return 0;
    endcase
  endfunction

  task automatic clearStats();
    curCycles = 0; curIr = 0; curPc = 0; curReg = 0; curMemW = 0;
    curFetchReq = 0; curDataReq = 0; sinceIr = -1;
    seenA = 2'b11; seenB = 2'b11; seenAlu = 4'hF; seenImm = 3'b111; lastRes = 2'b10;
  endtask

  // Issue one instruction: push its expected footprint, then drive its cycles.
  task automatic applyStimulus(input logic [6:0] opV, input logic [2:0] f3, input logic f7,
                               input logic [3:0] flg, input int fw, input int mw);
    exp_t e;
    int   lead, post;
    logic isMem;
    e = '{default: 0};
    isMem = 1'b0; post = 0; lead = 0;
    e.irW = 1; e.pcW = 1; e.fetchReq = fw + 1; e.imm = immModel(opV);
    e.chkAlu = 1'b1; e.aluCtl = 4'b0000; e.res = 2'b00;
    case (opV)
      LW:    begin lead = 2; isMem = 1'b1; post = 1; e.regW = 1; e.res = 2'b01;
                   e.dataReq = mw + 1; e.srcA = 2'b10; e.srcB = 2'b01; end
      SW:    begin lead = 2; isMem = 1'b1; e.memW = mw + 1; e.dataReq = mw + 1;
                   e.srcA = 2'b10; e.srcB = 2'b01; end
      RT:    begin lead = 3; e.regW = 1; e.srcA = 2'b10; e.srcB = 2'b00;
                   e.aluCtl = aluModel(f3, f7, 1'b1); end
      IT:    begin lead = 3; e.regW = 1; e.srcA = 2'b10; e.srcB = 2'b01;
                   e.aluCtl = aluModel(f3, f7, 1'b0); end
      BR:    begin lead = 2; e.pcW = 1 + takenModel(f3, flg); e.srcA = 2'b10; e.srcB = 2'b00;
                   e.aluCtl = 4'b0001; end
      JAL:   begin lead = 3; e.regW = 1; e.pcW = 2; e.srcA = 2'b01; e.srcB = 2'b10; end
      JALR:  begin lead = 4; e.regW = 1; e.pcW = 2; e.srcA = 2'b10; e.srcB = 2'b01; end
      LUI:   begin lead = 2; e.regW = 1; e.res = 2'b11; e.chkAlu = 1'b0; end
      default: begin lead = 3; e.regW = 1; e.srcA = 2'b01; e.srcB = 2'b01; end
    endcase
    e.cycles = fw + 1 + lead + (isMem ? (mw + 1 + post) : 0);
    modelCount = modelCount + 32'd1;
    e.instretAfter = modelCount;
    expQ.push_back(e);
    op = opV; funct3 = f3; funct7b5 = f7;
    {Zero, Negative, V, Carry} = flg;
    for (int c = 0; c <= fw; c++) begin mem_ready = (c == fw); tick(); end
    for (int c = 0; c < lead; c++) begin mem_ready = 1'($urandom_range(0, 1)); tick(); end
    if (isMem) begin
      for (int c = 0; c <= mw; c++) begin mem_ready = (c == mw); tick(); end
      for (int c = 0; c < post; c++) begin mem_ready = 1'($urandom_range(0, 1)); tick(); end
    end
  endtask

  // Monitor: accumulate activity per cycle and score it each time instret moves.
  always @(negedge clk) begin
    if (monEnable) begin
      if (instret !== lastInstret) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected retire", instret, lastInstret);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("cycles", curCycles, e.cycles);
          checkOutput("IRWrite count", curIr, e.irW);
          checkOutput("PCWrite count", curPc, e.pcW);
          checkOutput("RegWrite count", curReg, e.regW);
          checkOutput("MemWrite cycles", curMemW, e.memW);
          checkOutput("fetch req cycles", curFetchReq, e.fetchReq);
          checkOutput("data req cycles", curDataReq, e.dataReq);
          checkOutput("ImmSrc", 32'(seenImm), 32'(e.imm));
          if (e.chkAlu) begin
            checkOutput("ALUSrcA", 32'(seenA), 32'(e.srcA));
            checkOutput("ALUSrcB", 32'(seenB), 32'(e.srcB));
            checkOutput("ALUControl", 32'(seenAlu), 32'(e.aluCtl));
          end
          if (e.regW > 0) checkOutput("ResultSrc at RegWrite", 32'(lastRes), 32'(e.res));
          checkOutput("instret", instret, e.instretAfter);
        end
        lastInstret = instret;
        clearStats();
      end
      curCycles++;
      if (IRWrite) begin curIr++; sinceIr = 0; end
      else if (sinceIr >= 0) sinceIr++;
      if (sinceIr == 2) begin
        seenA = ALUSrcA; seenB = ALUSrcB; seenAlu = ALUControl; seenImm = ImmSrc;
      end
      if (PCWrite) curPc++;
      if (RegWrite) begin curReg++; lastRes = ResultSrc; end
      if (mem_req && MemWrite) curMemW++;
      if (mem_req && !AdrSrc) curFetchReq++;
      if (mem_req && AdrSrc) curDataReq++;
    end
  end

  initial begin
    logic [6:0] opList [9];
    opList = '{LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC};
    clearStats();
    reset = 1'b1; mem_ready = 1'b1; op = LUI; funct3 = 3'd0; funct7b5 = 1'b0;
    {Zero, Negative, V, Carry} = 4'b0000;

    // Reset held for three cycles: no request or strobes.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset mem_req", 32'(mem_req), 0);
      checkOutput("reset strobes", 32'({IRWrite, PCWrite, RegWrite, MemWrite}), 0);
    end
    checkOutput("reset instret", instret, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("first fetch mem_req", 32'(mem_req), 1);
    checkOutput("first fetch IRWrite/PCWrite", 32'({IRWrite, PCWrite}), 32'b11);
    checkOutput("first fetch AdrSrc", 32'(AdrSrc), 0);
    @(posedge clk); #1;
    tick();
    tick();
    checkOutput("instret after lui", instret, 1);
    checkOutput("fault clear", 32'(fault), 0);
    modelCount = 1; lastInstret = 1; monEnable = 1'b1;

    // Directed cases
    applyStimulus(LW, 3'd2, 1'b0, 4'b0000, 0, 2);
    applyStimulus(SW, 3'd2, 1'b0, 4'b0000, 0, 0);
    applyStimulus(BR, 3'b001, 1'b0, 4'b1000, 0, 0);
    applyStimulus(BR, 3'b100, 1'b0, 4'b0100, 0, 0);
    applyStimulus(BR, 3'b111, 1'b0, 4'b0000, 0, 0);
    applyStimulus(RT, 3'b000, 1'b1, 4'b0000, 1, 0);
    applyStimulus(IT, 3'b101, 1'b1, 4'b0000, 0, 0);
    applyStimulus(IT, 3'b000, 1'b1, 4'b0000, 2, 0);
    applyStimulus(JALR, 3'b000, 1'b0, 4'b0000, 0, 0);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      applyStimulus(opList[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Illegal opcode: FAULT after DECODE, then silent forever.
    op = 7'b0000000; funct3 = 3'd0; mem_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("fault flag", 32'(fault), 1);
      checkOutput("fault mem_req", 32'(mem_req), 0);
      checkOutput("fault strobes", 32'({IRWrite, PCWrite, RegWrite, MemWrite}), 0);
      checkOutput("fault instret frozen", instret, modelCount);
      @(posedge clk); #1;
    end
    monEnable = 1'b0;
    checkOutput("scoreboard drained", expQ.size(), 0);

    // Reset clears the fault and the counter.
    reset = 1'b1;
    #1;
    checkOutput("reset clears fault", 32'(fault), 0);
    checkOutput("reset clears instret", instret, 0);
    tick();
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("wait fetch mem_req", 32'(mem_req), 1);
    checkOutput("wait fetch IRWrite", 32'(IRWrite), 0);
    @(posedge clk); #1;
    mem_ready = 1'b1; reset = 1'b1;
    #1;
    checkOutput("mid-access reset mem_req", 32'(mem_req), 0);
    checkOutput("mid-access reset strobes", 32'({IRWrite, PCWrite}), 0);
    #10;
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
